req_encoder_rr: RTL and testbench
=================================

# req_encoder_rr

Registered, flow-controlled successor to the combinational one-hot encoder. It accepts an arbitrary (not necessarily one-hot) request vector, holds requests in a pending register, and emits one binary index per transaction over a valid/ready handshake. Selection is either fixed-priority or round-robin, so simultaneous requests are serialised rather than collapsed. It sits between the user-area request sources and any downstream consumer that needs one index at a time.

## Interface
- `N`, 64: request width; any value ≥ 2, not restricted to powers of two.
- `MODE`, 0: 0 = fixed priority (highest set index wins); 1 = round-robin.
- `K`, derived as $clog2(N): index width. Not overridable.
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_i`  in  N  request pulses; each set bit marks that index pending.
- `clr_i`  in  1  synchronous flush of pending state and the overflow flag.
- `out_valid`  out  1  `out_idx` holds a granted index.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_idx`  out  K  granted index.
- `out_multi`  out  1  another bit was still pending when this grant was taken.
- `pending_cnt`  out  K+1  popcount of the pending register.
- `overflow`  out  1  sticky: a request arrived for an index that was already pending.

## Operation
- Pending register `P[N-1:0]`. Output slot consists of `out_valid`, `out_idx` and `out_multi`.
- The slot is free when `!out_valid | out_ready`. When the slot is free and `P != 0`, pick index `g`:
  - Load the slot with `out_valid=1`, `out_idx=g`, and `out_multi` set to (popcount(P) > 1).
  - Clear `P[g]`.
- When the slot is free and `P == 0`, `out_valid` goes to 0.
- Pending update: `P_next = (P & ~pop_mask) | req_i`.
  - Set wins. A request on the bit being popped in the same cycle leaves that bit pending.
- Overflow: set when any `req_i[i]` hits an already-pending `P[i]` that is not popped that cycle. Stays set until `clr_i` or reset.
- MODE 0: `g` is the highest set index of P.
- MODE 1: rotating pointer `ptr[K-1:0]`, reset 0.
  - `g` is the first set bit searching upward from `ptr`, wrapping at N-1 → 0.
  - On each grant, `ptr` becomes g+1, or 0 if g = N-1. Pointer values ≥ N never occur.
- `clr_i`: `P` ← 0, `overflow` ← 0, and `req_i` in the same cycle is discarded. The held slot is not killed; a presented `out_valid` stays until accepted. `ptr` is unchanged.
- `pending_cnt` is combinational popcount of the registered `P`.
- The slot is stable while `out_valid & !out_ready`; `out_idx` and `out_multi` must not change.

## Timing
- Reset values: all outputs 0; `P` = 0; `ptr` = 0.
- Latency with the slot free: `req_i` in cycle t → bit in `P` at t+1 → `out_valid` with that index at t+2.
- Throughput: one grant per cycle with `out_ready` held high.
- Back-pressure: with `out_ready` low, P keeps accumulating; grants resume in the cycle after acceptance, with no bubble.
- Reset asserted mid-operation clears everything immediately, including a presented slot. No grant is emitted in the first cycle after release.

## Structure
- Package `req_encoder_pkg`:
  - `MODE_FIXED = 0`, `MODE_RR = 1`.
  - Popcount function, parametrised via a width argument.
- Sub-module `rr_pick`: combinational, N-wide. Inputs are the vector and `ptr`; outputs are `g` and `found`.
  - Implemented with the masked/unmasked double-search.
  - MODE 0 drives `rr_pick` with a constant pointer and bit-reversed ordering, or a separate highest-bit path inside the same module.
- Top level holds `P`, `ptr`, the slot, overflow, and `pending_cnt`.

## Test plan
1. N=8, MODE 0, `req_i`=0b1010_0100 for one cycle, `out_ready`=1 → `out_idx` = 7, 5, 2 on consecutive cycles starting at t+2. `out_multi` = 1, 1, 0. `pending_cnt` = 3 → 2 → 1 → 0.
2. N=8, MODE 1, `req_i`=0xFF held for 16 cycles, `out_ready`=1 → indices 0,1,…,7,0,1,… in strict rotation. `overflow` = 1 from the second request cycle.
3. N=8, MODE 1, `ptr` at 6, `P`=0b0000_0011 → grant 0, then 1; `ptr` ends at 2. This checks wrap-around.
4. Back-pressure: `out_ready`=0 for 5 cycles with `out_valid`=1 → `out_idx` and `out_multi` stable. Then raise `out_ready` → the next grant appears the following cycle.
5. Set-wins: `req_i[3]` pulsed in the same cycle bit 3 is popped → bit 3 is re-granted later and `overflow` stays 0. Then `clr_i` with `P`=0x30 → `pending_cnt`=0 and the held slot is still delivered.
6. N=5 (non-power-of-two), MODE 1, all bits requested → 0..4 repeating; `ptr` never reaches 5–7. Assert `rst_n` low mid-stream → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/req_encoder_pkg.sv
// Shared constants and helpers for the registered request encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MODE_FIXED / MODE_RR  selection policy codes for the MODE parameter
//   POP_MAX_W             widest vector the popcount helper accepts
//   popcount()            set-bit count of the low `width` bits of a vector
package req_encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int POP_MAX_W  = 1024;

  // Callers zero-extend their vector to POP_MAX_W; bits at or above
  // `width` are ignored so a narrower caller never counts padding.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec,
                                           input int unsigned          width);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < width) cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational index picker: round-robin from a pointer, or highest set bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   vec    candidate bits
//   ptr    round-robin start position (ignored in fixed-priority mode)
//   g      selected index (valid only when found)
//   found  vec has at least one bit set
module rr_pick
  import req_encoder_pkg::*;
#(
  parameter int  N    = 64,
  parameter int  MODE = MODE_FIXED,
  localparam int K    = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [K-1:0] ptr,
  output logic [K-1:0] g,
  output logic         found
);

  logic [N-1:0] masked;
  logic [K-1:0] lo_masked;
  logic [K-1:0] lo_any;
  logic [K-1:0] hi_any;
  logic         hit_masked;

  // Double search: the lowest set bit at or above ptr wins; if there is
  // none, the search has wrapped and the lowest set bit overall wins.
  always_comb begin
    masked     = '0;
    lo_masked  = '0;
    lo_any     = '0;
    hi_any     = '0;
    hit_masked = 1'b0;
    for (int i = 0; i < N; i++) begin
      masked[i] = vec[i] && (i >= int'(ptr));
    end
    // Descending scan so the last assignment is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        lo_masked  = K'(i);
        hit_masked = 1'b1;
      end
      if (vec[i]) lo_any = K'(i);
    end
    // Ascending scan so the last assignment is the highest index.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) hi_any = K'(i);
    end
  end

  assign found = |vec;
  assign g     = (MODE == MODE_RR) ? (hit_masked ? lo_masked : lo_any) : hi_any;

endmodule

// File: rtl/req_encoder_rr.sv
// Registered request encoder: accumulates request bits, emits one index per handshake.
// Latency: req_i at t -> pending at t+1 -> out_valid with that index at t+2.
// Backpressure: out_ready low holds the slot stable while pending keeps accumulating.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_i        request bits, OR-ed into the pending register
//   clr_i        synchronous flush of pending bits and overflow
//   out_valid / out_ready / out_idx / out_multi   output slot and handshake
//   pending_cnt  number of bits currently pending
//   overflow     sticky: a request hit an index that was still pending
module req_encoder_rr
  import req_encoder_pkg::*;
#(
  parameter int  N    = 64,
  parameter int  MODE = MODE_FIXED,
  localparam int K    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         clr_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_idx,
  output logic         out_multi,
  output logic [K:0]   pending_cnt,
  output logic         overflow
);

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [N-1:0] pop_mask;
  logic [K-1:0] ptr_q;
  logic [K-1:0] pick_g;
  logic         pick_found;
  logic         slot_free;
  logic         pop;
  logic         ovf_hit;

  rr_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .vec   (pend_q),
    .ptr   (ptr_q),
    .g     (pick_g),
    .found (pick_found)
  );

  assign pending_cnt = (K+1)'(popcount(POP_MAX_W'(pend_q), N));

  assign slot_free = !out_valid || out_ready;
  assign pop       = slot_free && pick_found;
  assign pop_mask  = pop ? (N'(1) << pick_g) : '0;

  // A request re-hitting the bit being popped this cycle is a fresh
  // request, not a lost one, so the popped bit is excluded here.
  assign ovf_hit = |(req_i & pend_q & ~pop_mask);

  // Set wins over pop; clear discards everything including same-cycle requests.
  assign pend_d = clr_i ? '0 : ((pend_q & ~pop_mask) | req_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_multi <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pend_q <= pend_d;

      if (clr_i) begin
        overflow <= 1'b0;
      end else if (ovf_hit) begin
        overflow <= 1'b1;
      end

      // The slot only reloads when free, so a stalled grant holds its
      // index and multi flag; clr_i deliberately leaves it alone.
      if (slot_free) begin
        out_valid <= pick_found;
        if (pick_found) begin
          out_idx   <= pick_g;
          out_multi <= (pending_cnt > (K+1)'(1));
        end
      end

      // Wrap explicitly at N-1 so non-power-of-two N never sees ptr >= N.
      if ((MODE == MODE_RR) && pop) begin
        ptr_q <= (pick_g == K'(N - 1)) ? '0 : (pick_g + K'(1));
      end
    end
  end

endmodule

// File: tb/tb_req_encoder_rr.sv
`timescale 1ns/1ps
module tb_req_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req [3];
  logic [2:0] clr;
  logic [2:0] rdy;

  logic       ov0, ov1, ov2;
  logic [2:0] idx0, idx1, idx2;
  logic       om0, om1, om2;
  logic [3:0] pc0, pc1, pc2;
  logic       of0, of1, of2;

  // u0: N=8 fixed priority, u1: N=8 round-robin, u2: N=5 round-robin
  req_encoder_rr #(.N(8), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .clr_i(clr[0]),
    .out_valid(ov0), .out_ready(rdy[0]), .out_idx(idx0), .out_multi(om0),
    .pending_cnt(pc0), .overflow(of0));

  req_encoder_rr #(.N(8), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .clr_i(clr[1]),
    .out_valid(ov1), .out_ready(rdy[1]), .out_idx(idx1), .out_multi(om1),
    .pending_cnt(pc1), .overflow(of1));

  req_encoder_rr #(.N(5), .MODE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req[2][4:0]), .clr_i(clr[2]),
    .out_valid(ov2), .out_ready(rdy[2]), .out_idx(idx2), .out_multi(om2),
    .pending_cnt(pc2), .overflow(of2));

  int n_tot  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int get_vld(input int u);
    case (u) 0: return int'(ov0); 1: return int'(ov1); default: return int'(ov2); endcase
  endfunction
  function automatic int get_idx(input int u);
    case (u) 0: return int'(idx0); 1: return int'(idx1); default: return int'(idx2); endcase
  endfunction
  function automatic int get_multi(input int u);
    case (u) 0: return int'(om0); 1: return int'(om1); default: return int'(om2); endcase
  endfunction
  function automatic int get_cnt(input int u);
    case (u) 0: return int'(pc0); 1: return int'(pc1); default: return int'(pc2); endcase
  endfunction
  function automatic int get_ovf(input int u);
    case (u) 0: return int'(of0); 1: return int'(of1); default: return int'(of2); endcase
  endfunction

  // ---------------- reference model ----------------
  int cfg_n    [3] = '{8, 8, 5};
  int cfg_mode [3] = '{0, 1, 1};
  bit m_pend [3][8];
  int m_ptr  [3];
  bit m_vld  [3];
  int m_idx  [3];
  int m_multi[3];
  bit m_ovf  [3];
  int q0[$], q1[$], q2[$];   // expected grants, encoded idx*2 + multi

  task automatic push(input int u, input int v);
    case (u) 0: q0.push_back(v); 1: q1.push_back(v); default: q2.push_back(v); endcase
  endtask
  function automatic int qsize(input int u);
    case (u) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  task automatic qpop(input int u, output int v);
    case (u) 0: v = q0.pop_front(); 1: v = q1.pop_front(); default: v = q2.pop_front(); endcase
  endtask

  function automatic int model_cnt(input int u);
    int c = 0;
    for (int j = 0; j < cfg_n[u]; j++) c += m_pend[u][j] ? 1 : 0;
    return c;
  endfunction

  // Fixed: highest pending index. Round-robin: first pending index met
  // walking upward from the pointer modulo N.
  function automatic int pick(input int u);
    int n = cfg_n[u];
    if (cfg_mode[u] == 0) begin
      for (int j = n - 1; j >= 0; j--) if (m_pend[u][j]) return j;
    end else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (m_ptr[u] + k) % n;
        if (m_pend[u][j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      for (int j = 0; j < 8; j++) m_pend[u][j] = 1'b0;
      m_ptr[u] = 0; m_vld[u] = 1'b0; m_idx[u] = 0; m_multi[u] = 0; m_ovf[u] = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic model_step(input int u, input bit [7:0] rq, input bit cl, input bit rd);
    int n, g, cnt;
    n = cfg_n[u];
    g = -1;
    cnt = model_cnt(u);
    if (!m_vld[u] || rd) begin
      g = pick(u);
      m_vld[u] = (g >= 0);
      if (g >= 0) begin
        m_idx[u]   = g;
        m_multi[u] = (cnt > 1) ? 1 : 0;
        push(u, g * 2 + m_multi[u]);
        m_ptr[u] = (g + 1) % n;
      end
    end
    if (cl) begin
      for (int j = 0; j < 8; j++) m_pend[u][j] = 1'b0;
      m_ovf[u] = 1'b0;
    end else begin
      for (int j = 0; j < n; j++) begin
        if (rq[j]) begin
          if (m_pend[u][j] && (j != g)) m_ovf[u] = 1'b1;
          m_pend[u][j] = 1'b1;
        end else if (j == g) begin
          m_pend[u][j] = 1'b0;
        end
      end
    end
  endtask

  // One clock: advance the model with the inputs currently driven, then
  // compare the cycle-level outputs just after the edge.
  task automatic step();
    for (int u = 0; u < 3; u++) model_step(u, req[u], clr[u], rdy[u]);
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("valid_u%0d", u), get_vld(u), int'(m_vld[u]));
      check($sformatf("pending_cnt_u%0d", u), get_cnt(u), model_cnt(u));
      check($sformatf("overflow_u%0d", u), get_ovf(u), int'(m_ovf[u]));
    end
  endtask

  task automatic set_all(input bit [7:0] r, input bit c, input bit d);
    for (int u = 0; u < 3; u++) begin
      req[u] = r; clr[u] = c; rdy[u] = d;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      for (int u = 0; u < 3; u++) begin
        if (get_vld(u) != 0 && rdy[u]) begin
          check($sformatf("idx_in_range_u%0d", u), (get_idx(u) < cfg_n[u]) ? 1 : 0, 1);
          if (qsize(u) == 0) begin
            check($sformatf("grant_expected_u%0d", u), 0, 1);
          end else begin
            qpop(u, e);
            check($sformatf("grant_idx_u%0d", u), get_idx(u), e / 2);
            check($sformatf("grant_multi_u%0d", u), get_multi(u), e % 2);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_all(8'h00, 1'b0, 1'b0);
    model_reset();
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_valid_u%0d", u), get_vld(u), 0);
      check($sformatf("rst_idx_u%0d", u), get_idx(u), 0);
      check($sformatf("rst_cnt_u%0d", u), get_cnt(u), 0);
      check($sformatf("rst_ovf_u%0d", u), get_ovf(u), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Fixed priority burst on u0; saturating requests on u1 and u2.
    req[0] = 8'hA4; req[1] = 8'hFF; req[2] = 8'h1F; rdy = 3'b111;
    step();
    check("t1_cnt_t1", get_cnt(0), 3);
    check("t1_valid_t1", get_vld(0), 0);
    req[0] = 8'h00;
    step();
    check("t1_idx_a", get_idx(0), 7); check("t1_multi_a", get_multi(0), 1); check("t1_cnt_a", get_cnt(0), 2);
    step();
    check("t1_idx_b", get_idx(0), 5); check("t1_multi_b", get_multi(0), 1); check("t1_cnt_b", get_cnt(0), 1);
    step();
    check("t1_idx_c", get_idx(0), 2); check("t1_multi_c", get_multi(0), 0); check("t1_cnt_c", get_cnt(0), 0);
    repeat (12) step();
    check("t2_overflow", get_ovf(1), 1);
    set_all(8'h00, 1'b0, 1'b1);
    repeat (12) step();

    // Set-wins, then clear while a grant is held.
    req[0] = 8'h08; step();
    req[0] = 8'h08; step();
    req[0] = 8'h00; step();
    check("t5_ovf_setwins", get_ovf(0), 0);
    check("t5_regrant_idx", get_idx(0), 3);
    req[0] = 8'h30; rdy[0] = 1'b0; step();
    check("t5_cnt_before_clr", get_cnt(0), 2);
    req[0] = 8'h00; clr[0] = 1'b1; step();
    check("t5_cnt_after_clr", get_cnt(0), 0);
    check("t5_held_valid", get_vld(0), 1);
    check("t5_held_idx", get_idx(0), 3);
    clr[0] = 1'b0; rdy[0] = 1'b1; step();
    check("t5_slot_drained", get_vld(0), 0);

    // Round-robin wrap on u1: move ptr to 6, then request bits 0 and 1.
    req[1] = 8'h20; step();
    req[1] = 8'h03; step();
    check("t3_idx5", get_idx(1), 5);
    req[1] = 8'h00; step();
    check("t3_wrap_idx0", get_idx(1), 0); check("t3_wrap_multi", get_multi(1), 1);
    step();
    check("t3_idx1", get_idx(1), 1); check("t3_multi1", get_multi(1), 0);
    req[1] = 8'h07; step();
    req[1] = 8'h00; step();
    check("t3_ptr_at_2", get_idx(1), 2);
    repeat (6) step();

    // Back-pressure: stall five cycles, slot must hold what was loaded.
    set_all(8'h3C, 1'b0, 1'b1);
    step();
    set_all(8'h00, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      for (int u = 0; u < 3; u++) begin
        check($sformatf("stall_idx_u%0d", u), get_idx(u), m_idx[u]);
        check($sformatf("stall_multi_u%0d", u), get_multi(u), m_multi[u]);
      end
    end
    rdy = 3'b111;
    step();
    check("bp_resume_valid", get_vld(0), 1);
    repeat (8) step();

    // Randomised traffic.
    for (int c = 0; c < 2500; c++) begin
      for (int u = 0; u < 3; u++) begin
        req[u] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        rdy[u] = ($urandom_range(0, 9) < 7);
        clr[u] = ($urandom_range(0, 59) == 0);
      end
      step();
    end

    // N=5 saturation, then reset mid-stream.
    set_all(8'h00, 1'b0, 1'b1);
    req[2] = 8'h1F; req[1] = 8'hFF;
    repeat (12) step();
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("midrst_valid_u%0d", u), get_vld(u), 0);
      check($sformatf("midrst_idx_u%0d", u), get_idx(u), 0);
      check($sformatf("midrst_multi_u%0d", u), get_multi(u), 0);
      check($sformatf("midrst_cnt_u%0d", u), get_cnt(u), 0);
      check($sformatf("midrst_ovf_u%0d", u), get_ovf(u), 0);
    end
    model_reset();
    set_all(8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req[2] = 8'h1F;
    step();
    check("post_rst_no_grant", get_vld(2), 0);
    repeat (10) step();

    set_all(8'h00, 1'b0, 1'b1);
    repeat (20) step();
    for (int u = 0; u < 3; u++) check($sformatf("queue_drained_u%0d", u), qsize(u), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
